mult_div_unit: RTL

Sequential 32-bit multiply/divide datapath that answers the control unit's MULT/DIV requests. The control unit raises `mult_op` or `div_op` and counts 32 cycles; this block accepts the request, iterates one bit per clock, and delivers the HI/LO pair with a one-cycle `done` pulse exactly when that count expires. Sits beside the ALU and feeds the HI/LO registers and the MFHI/MFLO path.

---
 rtl/mult_div_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit -- sequential 32-bit multiply/divide datapath for HI/LO.
//
// A multiply or divide is accepted in IDLE. The unit then iterates one bit
// per clock for 32 edges and registers the HI/LO pair on the last edge,
// together with a one-cycle done pulse.
//   Multiply: radix-2 Booth, one add/sub plus arithmetic right shift per edge.
//   Divide:   restoring division on operand magnitudes, signs fixed at the end.
//
// Optional feature macro: MULT_DIV_UNSIGNED_EN
//   When defined, the unsigned_op port exists and selects MULTU/DIVU.
//   When undefined, every operation is signed.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   mult_op      in   start signed multiply (sampled only in IDLE, wins over div_op)
//   div_op       in   start signed divide (sampled only in IDLE)
//   a, b         in   operands [31:0], captured on the start edge
//   unsigned_op  in   (MULT_DIV_UNSIGNED_EN only) unsigned operation
//   hi, lo       out  product[63:32]/[31:0] or remainder/quotient, held
//   busy         out  high while iterating
//   done         out  one-cycle pulse, hi/lo valid
//   div_by_zero  out  qualifies done for a divide whose divisor was zero
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        mult_op,
    input  logic        div_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic        unsigned_op,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    logic [32:0] r_acc;       // Booth accumulator / partial remainder
    logic [31:0] r_mq;        // multiplier / dividend-then-quotient
    logic        r_qm1;       // Booth q(-1)
    logic [31:0] r_divisor;   // divisor magnitude
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_uns;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;

    logic        w_uns;
    logic        w_start_mult;
    logic        w_start_div;
    logic        w_last;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_booth_sum;
    logic [32:0] w_booth_acc;
    logic [31:0] w_booth_mq;
    logic        w_booth_qm1;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic        w_div_fits;
    logic [32:0] w_div_acc;
    logic [31:0] w_div_mq;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_dbz;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_uns = unsigned_op;
`else
    assign w_uns = 1'b0;
`endif

    assign w_a_mag = (!w_uns && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag = (!w_uns && b[31]) ? (~b + 32'd1) : b;

    // Next-state logic; a start from IDLE is decided here too.
    always_comb begin
        w_state_next = r_state;
        w_start_mult = 1'b0;
        w_start_div  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mult_op) begin
                    w_state_next = S_MULT;
                    w_start_mult = 1'b1;
                end else if (div_op) begin
                    w_state_next = S_DIV;
                    w_start_div  = 1'b1;
                end
            end
            S_MULT, S_DIV: begin
                if (r_count == 5'd0) begin
                    w_state_next = S_IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Booth step. The accumulator is one bit wider than the operand so that
    // subtracting a most-negative multiplicand cannot overflow.
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_mq[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + {r_op_a[31], r_op_a};
            2'b10:   w_booth_sum = r_acc - {r_op_a[31], r_op_a};
            default: w_booth_sum = r_acc;
        endcase
        {w_booth_acc, w_booth_mq, w_booth_qm1} = {w_booth_sum[32], w_booth_sum, r_mq};
    end

    // Restoring-division step on magnitudes.
    always_comb begin
        w_div_shift = {r_acc[31:0], r_mq[31]};
        w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_divisor};
        w_div_fits  = ~w_div_diff[33];
        w_div_acc   = w_div_fits ? w_div_diff[32:0] : w_div_shift;
        w_div_mq    = {r_mq[30:0], w_div_fits};
    end

    // Final result as it would appear after the last iteration.
    always_comb begin
        w_res_hi  = 32'd0;
        w_res_lo  = 32'd0;
        w_res_dbz = 1'b0;
        if (r_state == S_MULT) begin
            // The Booth core forms the signed product; an unsigned product
            // differs only in the upper half by the operands whose top bit is set.
            w_res_lo = w_booth_mq;
            w_res_hi = w_booth_acc[31:0];
            if (r_uns) begin
                w_res_hi = w_booth_acc[31:0]
                         + (r_op_a[31] ? r_op_b : 32'd0)
                         + (r_op_b[31] ? r_op_a : 32'd0);
            end
        end else if (r_divisor == 32'd0) begin
            w_res_hi  = r_op_a;
            w_res_lo  = 32'hFFFF_FFFF;
            w_res_dbz = 1'b1;
        end else begin
            w_res_lo = (!r_uns && (r_op_a[31] ^ r_op_b[31])) ? (~w_div_mq + 32'd1) : w_div_mq;
            w_res_hi = (!r_uns && r_op_a[31]) ? (~w_div_acc[31:0] + 32'd1) : w_div_acc[31:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= 5'd31;
            r_acc     <= 33'd0;
            r_mq      <= 32'd0;
            r_qm1     <= 1'b0;
            r_divisor <= 32'd0;
            r_op_a    <= 32'd0;
            r_op_b    <= 32'd0;
            r_uns     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= w_last;
            r_dbz  <= w_last & w_res_dbz;
            if (w_start_mult || w_start_div) begin
                r_op_a    <= a;
                r_op_b    <= b;
                r_uns     <= w_uns;
                r_count   <= 5'd31;
                r_busy    <= 1'b1;
                r_acc     <= 33'd0;
                r_qm1     <= 1'b0;
                r_mq      <= w_start_mult ? b : w_a_mag;
                r_divisor <= w_b_mag;
            end else if (r_state == S_MULT) begin
                r_acc   <= w_booth_acc;
                r_mq    <= w_booth_mq;
                r_qm1   <= w_booth_qm1;
                r_count <= r_count - 5'd1;
            end else if (r_state == S_DIV) begin
                r_acc   <= w_div_acc;
                r_mq    <= w_div_mq;
                r_count <= r_count - 5'd1;
            end
            if (w_last) begin
                r_hi    <= w_res_hi;
                r_lo    <= w_res_lo;
                r_busy  <= 1'b0;
                r_count <= 5'd31;
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
